// File: rtl/divider_pkg.sv
// Shared definitions for the 32-bit iterative divider.
// Contents: datapath width, CALC step count, func_i operation codes,
// FSM state enum and a two's-complement magnitude helper.
package divider_pkg;

  localparam int XLEN       = 32;
  localparam int CALC_STEPS = 32;
  localparam int STEP_W     = 5;

  // {funct7, funct3} encodings of the RISC-V M-extension divide ops
  localparam logic [9:0] FUNC_DIV  = 10'b0000001_100;
  localparam logic [9:0] FUNC_DIVU = 10'b0000001_101;
  localparam logic [9:0] FUNC_REM  = 10'b0000001_110;
  localparam logic [9:0] FUNC_REMU = 10'b0000001_111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Magnitude of a signed 32-bit value; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle of the divider.
// Handshake: a request is accepted on the rising edge where
// valid_i && ready_o && !flush_i; A_i/B_i/func_i are only meaningful in that
// cycle. ready_o is high only while the divider is idle. valid_o is a one-cycle
// pulse marking a new result on out; there is no back-pressure on the result.
// flush_i kills the in-flight operation.
// Modports: slave = divider side, master = requester side.
interface divider_if;
  import divider_pkg::*;

  logic            valid_i;
  logic            ready_o;
  logic [XLEN-1:0] A_i;
  logic [XLEN-1:0] B_i;
  logic [9:0]      func_i;
  logic            flush_i;
  logic            valid_o;
  logic [XLEN-1:0] out;

  modport slave (
    input  valid_i, A_i, B_i, func_i, flush_i,
    output ready_o, valid_o, out
  );

  modport master (
    output valid_i, A_i, B_i, func_i, flush_i,
    input  ready_o, valid_o, out
  );

endinterface

// File: rtl/divider_div_step.sv
// div_step: one radix-2 restoring division step (purely combinational).
// Ports:
//   rem_i  partial remainder      quo_i  dividend/quotient shift register
//   div_i  divisor magnitude      rem_o/quo_o  values after this step
// The next dividend bit is shifted out of the top of quo_i while the new
// quotient bit enters at the bottom.
module div_step
  import divider_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          borrow;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    // rem_i < div_i keeps shifted below 2*div_i, so bit XLEN of diff is a
    // clean borrow flag and the kept remainder always fits in XLEN bits.
    borrow  = diff[XLEN];
    rem_o   = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/divider.sv
// divider: iterative 32-bit DIV/DIVU/REM/REMU unit.
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      divider_if.slave: valid_i/ready_o request, A_i/B_i/func_i
//            operands, flush_i kill, valid_o/out result
//   state_o  current FSM state (debug)
// Flow: IDLE -accept-> PREP (magnitudes, sign, special cases) -> CALC (32
// restoring steps) -> DONE (one-cycle result pulse) -> IDLE. Special cases
// (divide by zero, signed overflow, unknown func) skip CALC.
module divider
  import divider_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  divider_if.slave   bus,
  output state_e     state_o
);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [9:0]         func_q, func_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    dvs_q, dvs_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               neg_q, neg_d;
  logic               sel_rem_q, sel_rem_d;
  logic [XLEN-1:0]    out_q, out_d;

  logic [XLEN-1:0]    step_rem, step_quo;
  logic [XLEN-1:0]    raw_res, result;
  logic               accept, done_fire;
  logic               is_div, is_divu, is_rem, is_remu, is_signed, known;
  logic               div0, ovf;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign accept    = bus.valid_i && (state_q == ST_IDLE) && !bus.flush_i;
  // A flush in DONE suppresses the pulse and leaves out at its old value.
  assign done_fire = (state_q == ST_DONE) && !bus.flush_i;

  assign raw_res = sel_rem_q ? rem_q : quo_q;
  assign result  = neg_q ? (~raw_res + 32'd1) : raw_res;

  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.valid_o = done_fire;
  assign bus.out     = done_fire ? result : out_q;
  assign state_o     = state_q;

  // Operation decode and special-case detection on the captured request
  always_comb begin
    is_div    = (func_q == FUNC_DIV);
    is_divu   = (func_q == FUNC_DIVU);
    is_rem    = (func_q == FUNC_REM);
    is_remu   = (func_q == FUNC_REMU);
    is_signed = is_div || is_rem;
    known     = is_div || is_divu || is_rem || is_remu;
    div0      = (b_q == '0);
    ovf       = is_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    step_d    = step_q;
    neg_d     = neg_q;
    sel_rem_d = sel_rem_q;
    out_d     = out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = bus.A_i;
          b_d     = bus.B_i;
          func_d  = bus.func_i;
          state_d = ST_PREP;
        end
      end

      ST_PREP: begin
        sel_rem_d = is_rem || is_remu;
        step_d    = '0;
        rem_d     = '0;
        quo_d     = is_signed ? abs32(a_q) : a_q;
        dvs_d     = is_signed ? abs32(b_q) : b_q;
        // Quotient sign is the XOR of operand signs; remainder follows the
        // dividend.
        neg_d     = is_signed && (is_rem ? a_q[XLEN-1] : (a_q[XLEN-1] ^ b_q[XLEN-1]));
        state_d   = ST_CALC;
        // Special results are parked in rem/quo with neg cleared so DONE
        // presents them through the normal result path.
        if (!known) begin
          sel_rem_d = 1'b0;
          neg_d     = 1'b0;
          quo_d     = '0;
          state_d   = ST_DONE;
        end else if (div0) begin
          neg_d     = 1'b0;
          rem_d     = a_q;
          quo_d     = '1;
          state_d   = ST_DONE;
        end else if (ovf) begin
          neg_d     = 1'b0;
          rem_d     = '0;
          quo_d     = 32'h8000_0000;
          state_d   = ST_DONE;
        end
      end

      ST_CALC: begin
        rem_d  = step_rem;
        quo_d  = step_quo;
        step_d = step_q + 5'd1;
        if (step_q == STEP_W'(CALC_STEPS - 1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (done_fire) begin
          out_d = result;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Pipeline kill: abandon any in-flight operation.
    if (bus.flush_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      step_q    <= '0;
      neg_q     <= 1'b0;
      sel_rem_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      step_q    <= step_d;
      neg_q     <= neg_d;
      sel_rem_q <= sel_rem_d;
      out_q     <= out_d;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Testbench for divider: directed vectors with hand-computed results, a
// held-valid random phase checked against a behavioural model, flush and
// mid-operation reset. Expected results and latencies are queued at issue and
// checked by an independent monitor whenever valid_o is seen.
module tb_divider;
  import divider_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e state;
  int     cyc;

  int n_checks;
  int n_pass;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic        prev_valid;

  divider_if dif ();

  divider dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (dif.slave),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [9:0] f);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      FUNC_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      FUNC_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      FUNC_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      FUNC_REMU: return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic [9:0] f);
    logic sgn, known;
    sgn   = (f == FUNC_DIV) || (f == FUNC_REM);
    known = sgn || (f == FUNC_DIVU) || (f == FUNC_REMU);
    if (!known || b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 34;
  endfunction

  // Latency counts from the accept edge to the edge that samples valid_o.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [9:0] f,
                          input logic [31:0] exp, input int lat);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    acc_q.push_back(cyc + 1);
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [9:0] f,
                       input bit track, input logic [31:0] exp, input int lat);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!dif.ready_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!dif.ready_o) fail_now("ready_timeout", "ready_o never rose within 200 cycles");
    dif.valid_i = 1'b1;
    dif.A_i     = a;
    dif.B_i     = b;
    dif.func_i  = f;
    if (track) push_exp(a, b, f, exp, lat);
    @(negedge clk);
    dif.valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (exp_q.size() != 0 || state != ST_IDLE); k++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("drain", $sformatf("%0d results outstanding, required 0", exp_q.size()));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (dif.valid_o) begin
      check("valid_pulse", 32'(prev_valid), 32'h0);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_valid", $sformatf("valid_o with out=0x%08h, required no result", dif.out));
      end else begin
        int lat;
        logic [31:0] e;
        e   = exp_q.pop_front();
        lat = cyc - acc_q.pop_front() + 1;
        check("result", dif.out, e);
        check("latency", 32'(lat), 32'(lat_q.pop_front()));
      end
    end
    prev_valid <= dif.valid_o;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra, rb;
    logic [9:0]  rf;
    logic [9:0]  funcs[5];
    funcs[0] = FUNC_DIV;  funcs[1] = FUNC_DIVU;
    funcs[2] = FUNC_REM;  funcs[3] = FUNC_REMU;
    funcs[4] = 10'h3FF;

    n_checks    = 0;
    n_pass      = 0;
    cyc         = 0;
    prev_valid  = 1'b0;
    rst_n       = 1'b0;
    dif.valid_i = 1'b0;
    dif.flush_i = 1'b0;
    dif.A_i     = '0;
    dif.B_i     = '0;
    dif.func_i  = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(dif.ready_o), 32'h1);
    check("rst_valid", 32'(dif.valid_o), 32'h0);
    check("rst_out",   dif.out, 32'h0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Directed vectors, hand-computed
    issue(32'hFFFF_FFF9, 32'd2, FUNC_DIV,  1, 32'hFFFF_FFFD, 34); // -7/2 = -3
    issue(32'hFFFF_FFF9, 32'd2, FUNC_REM,  1, 32'hFFFF_FFFF, 34); // -7%2 = -1
    issue(32'd7, 32'hFFFF_FFFE, FUNC_DIV,  1, 32'hFFFF_FFFD, 34); // 7/-2 = -3
    issue(32'd7, 32'hFFFF_FFFE, FUNC_REM,  1, 32'h0000_0001, 34); // 7%-2 = 1
    issue(32'd5, 32'd0, FUNC_DIV,  1, 32'hFFFF_FFFF, 2);
    issue(32'd5, 32'd0, FUNC_REMU, 1, 32'h0000_0005, 2);
    issue(32'h8000_0000, 32'hFFFF_FFFF, FUNC_DIV, 1, 32'h8000_0000, 2);
    issue(32'h8000_0000, 32'hFFFF_FFFF, FUNC_REM, 1, 32'h0000_0000, 2);
    issue(32'd100, 32'd7, 10'h000, 1, 32'h0, 2);                  // unsupported
    issue(32'hFFFF_FFFF, 32'd16, FUNC_DIVU, 1, 32'h0FFF_FFFF, 34);
    issue(32'd100, 32'd7, FUNC_DIVU, 1, 32'd14, 34);
    issue(32'd100, 32'd7, FUNC_REMU, 1, 32'd2, 34);
    drain();

    // Flush in IDLE: request must be ignored
    @(negedge clk);
    dif.valid_i = 1'b1; dif.flush_i = 1'b1;
    dif.A_i = 32'd9; dif.B_i = 32'd3; dif.func_i = FUNC_DIVU;
    @(negedge clk);
    dif.valid_i = 1'b0; dif.flush_i = 1'b0;
    check("idle_flush_state", 32'(state), 32'(ST_IDLE));

    // Flush in CALC step 10: no result, ready next cycle, out unchanged
    issue(32'd100, 32'd7, FUNC_DIVU, 0, 32'h0, 0);   // returns in PREP
    repeat (11) @(negedge clk);                      // CALC, step 10
    check("flush_in_calc", 32'(state), 32'(ST_CALC));
    dif.flush_i = 1'b1;
    @(negedge clk);
    dif.flush_i = 1'b0;
    check("flush_ready", 32'(dif.ready_o), 32'h1);
    check("flush_out", dif.out, 32'd2);
    issue(32'd9, 32'd3, FUNC_DIVU, 1, 32'd3, 34);
    drain();

    // Held valid_i with random operands; accepts only when ready_o is high
    dif.valid_i = 1'b1;
    for (int i = 0; i < 450; i++) begin
      ra = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      rf = funcs[$urandom_range(0, 4)];
      dif.A_i    = ra;
      dif.B_i    = rb;
      dif.func_i = rf;
      if (dif.ready_o) push_exp(ra, rb, rf, model(ra, rb, rf), model_lat(ra, rb, rf));
      @(negedge clk);
    end
    dif.valid_i = 1'b0;
    drain();

    // Reset pulsed mid-CALC: operation abandoned, outputs at reset values
    issue(32'd1000, 32'd3, FUNC_DIVU, 0, 32'h0, 0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(state), 32'(ST_IDLE));
    check("midrst_ready", 32'(dif.ready_o), 32'h1);
    check("midrst_valid", 32'(dif.valid_o), 32'h0);
    check("midrst_out",   dif.out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);                      // any stray valid_o is flagged

    issue(32'd1000, 32'd3, FUNC_REMU, 1, 32'd1, 34);
    drain();
    check("final_queue", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
